// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle RISC-V controller: FSM states, opcodes,
// ALU control/ALUOp codes and the Moore output decode per state.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_e;

    // Unconditional (pure Moore) part of the outputs; conditional terms are added in the top.
    typedef struct packed {
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic       done;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_e    alu_op;
    } moore_t;

    function automatic moore_t moore_out(input state_e s);
        moore_t m;
        m = '0;
        case (s)
            StFetch: begin
                m.result_src = 2'b10;
                m.alu_src_b  = 2'b10;
            end
            StDecode: begin
                m.alu_src_a = 2'b01;
                m.alu_src_b = 2'b01;
            end
            StMemAdr: begin
                m.alu_src_a = 2'b10;
                m.alu_src_b = 2'b01;
            end
            StMemRead: m.adr_src = 1'b1;
            StMemWb: begin
                m.result_src = 2'b01;
                m.reg_write  = 1'b1;
                m.done       = 1'b1;
            end
            StMemWrite: begin
                m.adr_src   = 1'b1;
                m.mem_write = 1'b1;
            end
            StExecR: begin
                m.alu_src_a = 2'b10;
                m.alu_op    = AluOpFunct;
            end
            StExecI: begin
                m.alu_src_a = 2'b10;
                m.alu_src_b = 2'b01;
                m.alu_op    = AluOpFunct;
            end
            StAluWb: begin
                m.reg_write = 1'b1;
                m.done      = 1'b1;
            end
            StBranch: begin
                m.alu_src_a = 2'b10;
                m.alu_op    = AluOpSub;
                m.done      = 1'b1;
            end
            StJal: begin
                m.alu_src_a = 2'b01;
                m.alu_src_b = 2'b10;
                m.pc_write  = 1'b1;
                m.reg_write = 1'b1;
                m.done      = 1'b1;
            end
            default: ;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OpLoad, OpItype: return 2'b00;
            OpStore:         return 2'b01;
            OpBranch:        return 2'b10;
            OpJal:           return 2'b11;
            default:         return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction/flag inputs and datapath control outputs of the multicycle controller.
// master: controller side; slave: datapath side.
interface multicycle_controller_if #(
    parameter int unsigned ALUCTRL_W = 3
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7;
    logic                 zero;
    logic                 lt;
    logic                 mem_ready;
    logic                 PCWrite;
    logic                 IRWrite;
    logic                 RegWrite;
    logic                 MemWrite;
    logic                 AdrSrc;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ImmSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 instr_done;
    logic                 illegal;

    modport master (
        input  op, funct3, funct7, zero, lt, mem_ready,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, instr_done, illegal
    );

    modport slave (
        output op, funct3, funct7, zero, lt, mem_ready,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, instr_done, illegal
    );
endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: ALUOp plus funct fields to ALUControl, zero-extended to
// ALUCTRL_W bits.
module mc_alu_decoder
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3
) (
    input  alu_op_e              alu_op,
    input  logic [2:0]           funct3,
    input  logic                 funct7,
    input  logic                 op5,
    output logic [ALUCTRL_W-1:0] alu_control
);

    alu_ctrl_e ctrl;

    always_comb begin
        ctrl = AluAdd;
        case (alu_op)
            AluOpSub: ctrl = AluSub;
            AluOpFunct: begin
                case (funct3)
                    // Only R-type (op[5]=1) can subtract; addi ignores bit 30.
                    3'b000:  ctrl = (op5 && funct7) ? AluSub : AluAdd;
                    3'b010:  ctrl = AluSlt;
                    3'b110:  ctrl = AluOr;
                    3'b111:  ctrl = AluAnd;
                    default: ctrl = AluAdd;
                endcase
            end
            default: ctrl = AluAdd;
        endcase
    end

    assign alu_control = ALUCTRL_W'(ctrl);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM (lw/sw/R/I/beq/jal). Defining MC_CTRL_BRANCH_EXT_EN adds
// BNE/BLT/BGE evaluation in the BRANCH state.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned ALUCTRL_W       = 3,
    parameter int unsigned FETCH_PC_OFFSET = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    multicycle_controller_if.master bus
);

    state_e state_q, state_d;
    moore_t moore_q;
    logic   illegal_op;
    logic   taken;
    logic   fetch_go;

    // PC increment is fixed by ALUSrcB=10 in FETCH; the parameter only documents it.
    logic [31:0] unused_pc_offset;
    assign unused_pc_offset = 32'(FETCH_PC_OFFSET);

    always_comb begin
        state_d    = state_q;
        illegal_op = 1'b0;
        unique case (state_q)
            StFetch:    if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                case (bus.op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecR;
                    OpItype:         state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    default: begin
                        state_d    = StFetch;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            StMemAdr:   state_d = bus.op[5] ? StMemWrite : StMemRead;
            StMemRead:  if (bus.mem_ready) state_d = StMemWb;
            StMemWrite: if (bus.mem_ready) state_d = StFetch;
            StExecR, StExecI: state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            moore_q <= moore_out(StFetch);
        end else begin
            state_q <= state_d;
            moore_q <= moore_out(state_d);
        end
    end

`ifdef MC_CTRL_BRANCH_EXT_EN
    always_comb begin
        case (bus.funct3)
            3'b001:  taken = !bus.zero;
            3'b100:  taken = bus.lt;
            3'b101:  taken = !bus.lt;
            default: taken = bus.zero;
        endcase
    end
`else
    assign taken = bus.zero;
    logic unused_lt;
    assign unused_lt = bus.lt;
`endif

    // rst_n gates the fetch handshake so no enable can assert while reset is held.
    assign fetch_go = rst_n && (state_q == StFetch) && bus.mem_ready;

    assign bus.IRWrite    = fetch_go;
    assign bus.PCWrite    = fetch_go || moore_q.pc_write || ((state_q == StBranch) && taken);
    assign bus.RegWrite   = moore_q.reg_write;
    assign bus.MemWrite   = moore_q.mem_write;
    assign bus.AdrSrc     = moore_q.adr_src;
    assign bus.ResultSrc  = moore_q.result_src;
    assign bus.ALUSrcA    = moore_q.alu_src_a;
    assign bus.ALUSrcB    = moore_q.alu_src_b;
    assign bus.ImmSrc     = imm_src(bus.op);
    assign bus.illegal    = (state_q == StDecode) && illegal_op;
    assign bus.instr_done = moore_q.done || bus.illegal ||
                            ((state_q == StMemWrite) && bus.mem_ready);

    mc_alu_decoder #(
        .ALUCTRL_W(ALUCTRL_W)
    ) u_alu_decoder (
        .alu_op     (moore_q.alu_op),
        .funct3     (bus.funct3),
        .funct7     (bus.funct7),
        .op5        (bus.op[5]),
        .alu_control(bus.ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle vector table plus reset and
// cycle-count sequences.
module tb_multicycle_controller;

    localparam logic [6:0] OpLw  = 7'b0000011;
    localparam logic [6:0] OpSw  = 7'b0100011;
    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpBr  = 7'b1100011;
    localparam logic [6:0] OpJal = 7'b1101111;

    logic clk;
    logic rst_n;

    multicycle_controller_if #(.ALUCTRL_W(3)) bus ();

    multicycle_controller #(
        .ALUCTRL_W      (3),
        .FETCH_PC_OFFSET(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Field order: pcw irw rw mw adr | res | srca | srcb | imm | aluc | done ill
    typedef struct packed {
        logic       pcw, irw, rw, mw, adr;
        logic [1:0] res, srca, srcb, imm;
        logic [2:0] aluc;
        logic       done, ill;
    } exp_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z, lt, rdy;
        exp_t       e;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t cur();
        return {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl,
                bus.instr_done, bus.illegal};
    endfunction

    function automatic exp_t fetch_e(input logic [1:0] imm, input logic rdy);
        return {rdy, rdy, 3'b000, 2'b10, 2'b00, 2'b10, imm, 3'b000, 2'b00};
    endfunction

    function automatic exp_t decode_e(input logic [1:0] imm, input logic ill);
        return {5'b00000, 2'b00, 2'b01, 2'b01, imm, 3'b000, ill, ill};
    endfunction

    function automatic exp_t reset_e(input logic [1:0] imm);
        return {5'b00000, 2'b10, 2'b00, 2'b10, imm, 3'b000, 2'b00};
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, want);
        end
    endtask

    task automatic check_int(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input logic lt, input logic rdy);
        bus.op        = op;
        bus.funct3    = f3;
        bus.funct7    = f7;
        bus.zero      = z;
        bus.lt        = lt;
        bus.mem_ready = rdy;
    endtask

    task automatic step(input logic [6:0] op, input logic rdy);
        drive(op, 3'b000, 1'b0, 1'b0, 1'b0, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push(input string n, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input logic z, input logic lt, input logic rdy,
                        input exp_t e);
        vec_t v;
        v.name = n;
        v.op   = op;
        v.f3   = f3;
        v.f7   = f7;
        v.z    = z;
        v.lt   = lt;
        v.rdy  = rdy;
        v.e    = e;
        vecs.push_back(v);
    endtask

    task automatic add_alu(input string n, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [1:0] srcb, input logic [2:0] aluc);
        push({n, "_fetch"}, op, f3, f7, 1'b0, 1'b0, 1'b1, fetch_e(2'b00, 1'b1));
        push({n, "_decode"}, op, f3, f7, 1'b0, 1'b0, 1'b1, decode_e(2'b00, 1'b0));
        push({n, "_exec"}, op, f3, f7, 1'b0, 1'b0, 1'b1,
             {5'b00000, 2'b00, 2'b10, srcb, 2'b00, aluc, 2'b00});
        push({n, "_aluwb"}, op, f3, f7, 1'b0, 1'b0, 1'b1,
             {5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10});
    endtask

    task automatic add_branch(input string n, input logic [2:0] f3, input logic z,
                              input logic lt, input logic pcw);
        push({n, "_fetch"}, OpBr, f3, 1'b0, z, lt, 1'b1, fetch_e(2'b10, 1'b1));
        push({n, "_decode"}, OpBr, f3, 1'b0, z, lt, 1'b1, decode_e(2'b10, 1'b0));
        push({n, "_branch"}, OpBr, f3, 1'b0, z, lt, 1'b1,
             {pcw, 4'b0000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 2'b10});
    endtask

    task automatic build_table();
        // lw with memory always ready: 5 cycles, RegWrite and done in MEMWB
        push("lw_fetch", OpLw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, fetch_e(2'b00, 1'b1));
        push("lw_decode", OpLw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, decode_e(2'b00, 1'b0));
        push("lw_memadr", OpLw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1,
             {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00});
        push("lw_memread", OpLw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1,
             {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00});
        push("lw_memwb", OpLw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1,
             {5'b00100, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10});
        // sw: fetch stall, then MEMWRITE held 3 cycles: MemWrite 4 cycles, done once
        push("sw_fetch_wait", OpSw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, fetch_e(2'b01, 1'b0));
        push("sw_fetch", OpSw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, fetch_e(2'b01, 1'b1));
        push("sw_decode", OpSw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, decode_e(2'b01, 1'b0));
        push("sw_memadr", OpSw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1,
             {5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 2'b00});
        for (int i = 0; i < 3; i++) begin
            push($sformatf("sw_memwrite_wait%0d", i), OpSw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0,
                 {5'b00011, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 2'b00});
        end
        push("sw_memwrite_last", OpSw, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1,
             {5'b00011, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 2'b10});
        // ALU instructions
        add_alu("r_sub", OpR, 3'b000, 1'b1, 2'b00, 3'b001);
        add_alu("r_add", OpR, 3'b000, 1'b0, 2'b00, 3'b000);
        add_alu("r_or", OpR, 3'b110, 1'b0, 2'b00, 3'b011);
        add_alu("r_slt", OpR, 3'b010, 1'b0, 2'b00, 3'b101);
        add_alu("i_addi_b30", OpI, 3'b000, 1'b1, 2'b01, 3'b000);
        add_alu("i_andi", OpI, 3'b111, 1'b0, 2'b01, 3'b010);
        add_alu("i_slli", OpI, 3'b001, 1'b0, 2'b01, 3'b000);
        // branches
        add_branch("beq_nt", 3'b000, 1'b0, 1'b0, 1'b0);
        add_branch("beq_t", 3'b000, 1'b1, 1'b0, 1'b1);
`ifdef MC_CTRL_BRANCH_EXT_EN
        add_branch("bne_t", 3'b001, 1'b0, 1'b0, 1'b1);
        add_branch("bne_nt", 3'b001, 1'b1, 1'b0, 1'b0);
        add_branch("blt_t", 3'b100, 1'b0, 1'b1, 1'b1);
        add_branch("bge_nt", 3'b101, 1'b0, 1'b1, 1'b0);
`else
        add_branch("f3_001_nt", 3'b001, 1'b0, 1'b0, 1'b0);
        add_branch("f3_100_lt_ignored", 3'b100, 1'b0, 1'b1, 1'b0);
        add_branch("f3_101_zero_t", 3'b101, 1'b1, 1'b0, 1'b1);
`endif
        // jal
        push("jal_fetch", OpJal, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, fetch_e(2'b11, 1'b1));
        push("jal_decode", OpJal, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, decode_e(2'b11, 1'b0));
        push("jal_exec", OpJal, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1,
             {5'b10100, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 2'b10});
        // illegal opcodes return straight to FETCH
        push("ill0_fetch", 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, fetch_e(2'b00, 1'b1));
        push("ill0_decode", 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, decode_e(2'b00, 1'b1));
        push("ill7f_fetch", 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, fetch_e(2'b00, 1'b1));
        push("ill7f_decode", 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, decode_e(2'b00, 1'b1));
        push("after_illegal_fetch", OpLw, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, fetch_e(2'b00, 1'b0));
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].lt, vecs[i].rdy);
            @(negedge clk);
            check(vecs[i].name, cur(), vecs[i].e);
            @(posedge clk);
            #1;
        end
    endtask

    // Runs one lw from FETCH with mem_ready low in the cycles flagged by stall_mask
    // (bit c = cycle c, starting at 1) and checks latency and RegWrite at completion.
    task automatic time_lw(input string n, input logic [31:0] stall_mask, input int want);
        int done_at = 0;
        int n_done  = 0;
        logic rw_at_done = 1'b0;
        for (int c = 1; c <= 30 && done_at == 0; c++) begin
            drive(OpLw, 3'b010, 1'b0, 1'b0, 1'b0, !stall_mask[c]);
            @(negedge clk);
            if (bus.instr_done) begin
                done_at    = c;
                rw_at_done = bus.RegWrite;
                n_done++;
            end
            @(posedge clk);
            #1;
        end
        check_int({n, "_cycles"}, done_at, want);
        check_int({n, "_regwrite_at_done"}, int'(rw_at_done), 1);
        check_int({n, "_done_pulses"}, n_done, 1);
    endtask

    initial begin
        rst_n = 1'b1;
        drive(OpLw, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #2;
        check("reset_outputs", cur(), reset_e(2'b00));
        @(posedge clk);
        #1 rst_n = 1'b1;

        build_table();
        run_table();

        // Asynchronous reset while waiting in MEMREAD
        do_reset();
        step(OpLw, 1'b1);
        step(OpLw, 1'b1);
        step(OpLw, 1'b1);
        drive(OpLw, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_int("memread_adrsrc", int'(bus.AdrSrc), 1);
        @(posedge clk);
        #1;
        drive(OpLw, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_memread", cur(), reset_e(2'b00));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("first_fetch_after_reset", cur(), fetch_e(2'b00, 1'b1));
        @(posedge clk);
        #1;

        // Asynchronous reset while MemWrite is held in MEMWRITE
        do_reset();
        step(OpSw, 1'b1);
        step(OpSw, 1'b1);
        step(OpSw, 1'b1);
        drive(OpSw, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_int("memwrite_active", int'(bus.MemWrite), 1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_memwrite", cur(), reset_e(2'b01));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Latency of lw with and without memory stalls
        time_lw("lw_ready", 32'h0000_0000, 5);
        time_lw("lw_stalled", 32'h0000_00C6, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALUCTRL_W, default 3: ALUControl width; values above 3 zero-extend the 3-bit code.
REQ-002 Parameter FETCH_PC_OFFSET, default 4: informational only; controller drives ALUSrcB=10 (constant) in FETCH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 op  input  7  instruction opcode (from IR).
REQ-006 funct3  input  3  instruction funct3.
REQ-007 funct7  input  1  instruction bit 30 (funct7[5]).
REQ-008 zero  input  1  ALU zero flag.
REQ-009 lt  input  1  ALU signed less-than flag (used only with macro).
REQ-010 mem_ready  input  1  memory handshake: access completes in a cycle where high.
REQ-011 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  output  1 each  datapath enables/select.
REQ-012 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
REQ-013 ALUControl  output  ALUCTRL_W  ALU op: add 000, sub 001, and 010, or 011, slt 101.
REQ-014 instr_done  output  1  one-cycle pulse on the last cycle of each instruction.
REQ-015 illegal  output  1  one-cycle pulse in DECODE for unsupported opcode.

Function
REQ-016 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL; outputs Moore except PCWrite in BRANCH, IRWrite/PCWrite in FETCH, mem-wait gating.
REQ-017 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp add, ResultSrc=10; IRWrite=PCWrite=1 only when mem_ready=1; stays in FETCH while mem_ready=0; mem_ready=1 -> DECODE.
REQ-018 DECODE: ALUSrcA=01, ALUSrcB=01, add; op 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL; any other op -> FETCH with illegal=1 and instr_done=1.
REQ-019 MEMADR: ALUSrcA=10, ALUSrcB=01, add; op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
REQ-020 MEMREAD: AdrSrc=1, ResultSrc=00; waits on mem_ready=0; mem_ready=1 -> MEMWB.
REQ-021 MEMWB: ResultSrc=01, RegWrite=1, instr_done=1 -> FETCH.
REQ-022 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle until mem_ready=1; then instr_done=1 -> FETCH.
REQ-023 EXECR: ALUSrcA=10, ALUSrcB=00, funct decode; EXECI: ALUSrcA=10, ALUSrcB=01, funct decode; both -> ALUWB.
REQ-024 ALUWB: ResultSrc=00, RegWrite=1, instr_done=1 -> FETCH.
REQ-025 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite=1 iff taken (BEQ: zero=1); instr_done=1 -> FETCH.
REQ-026 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, RegWrite=1, instr_done=1 -> FETCH.
REQ-027 Funct decode: funct3 000 -> sub if op[5]&funct7 else add; 010 -> slt; 110 -> or; 111 -> and; others -> add.
REQ-028 ImmSrc combinational from op: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.
REQ-029 All unlisted enables SHALL be 0 in every state; selects default 00.

Reset
REQ-030 rst_n low SHALL force FETCH immediately, asynchronously, with all enables, instr_done and illegal 0, including mid-wait in MEMREAD/MEMWRITE.
REQ-031 First state after rst_n deasserts SHALL be FETCH.

Configuration
REQ-032 Macro MC_CTRL_BRANCH_EXT_EN defined: BRANCH also handles funct3 001 BNE (taken zero=0), 100 BLT (taken lt=1), 101 BGE (taken lt=0).
REQ-033 Macro undefined: BRANCH evaluates only BEQ; any funct3 uses zero=1 as taken; lt ignored.

Structure
REQ-034 Shared package SHALL hold state enum, opcode constants, ALUControl codes, ALUOp codes.
REQ-035 One sub-module mc_alu_decoder (ALUOp, funct3, funct7, op[5] -> ALUControl), combinational.

Verification
REQ-036 Reset: rst_n=0 mid-MEMREAD -> state FETCH, all enables 0 same cycle.
REQ-037 lw, mem_ready=1 always -> 5 cycles FETCH/DECODE/MEMADR/MEMREAD/MEMWB, RegWrite=1 cycle 5, instr_done on cycle 5.
REQ-038 sw with mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, instr_done once.
REQ-039 R-type sub (funct3=000, funct7=1) -> ALUControl=001 in EXECR, RegWrite in ALUWB, 4 cycles.
REQ-040 beq zero=0 -> PCWrite=0 in BRANCH; zero=1 -> PCWrite=1; with macro, bne zero=0 -> PCWrite=1.
REQ-041 op=0000000 -> illegal=1 in DECODE, next state FETCH.
